// File: rtl/mem_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the memory access arbiter slice.
//   arb_state_t : IDLE -> ADDR -> DATA -> DONE transaction sequence
//   ADDR_W      : default address width
//   DATA_W      : default data bus width (must be >= ADDR_W)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA,
    ARB_DONE
  } arb_state_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter_if
// Bundles the two requester handshakes and the MemoryController/data-bus
// signals of the memory access arbiter.
//   req0/we0/addr0/wdata0/ack0 : requester 0 (CPU) transaction port
//   req1/we1/addr1/wdata1/ack1 : requester 1 (loader/DMA) transaction port
//   rdata                      : read data, valid with ack
//   programming_mode           : front panel owns memory, blocks new grants
//   bus_in/bus_out/bus_oe      : resolved bus value, drive value, drive enable
//   set_mar/read_m/write_m     : MemoryController strobes
//   busy/grant_id              : status
// Modports: slave = the arbiter, master = requesters plus memory side.
// ---------------------------------------------------------------------------
interface mem_access_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;

  logic [DATA_W-1:0] rdata;
  logic              programming_mode;

  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;

  logic              set_mar;
  logic              read_m;
  logic              write_m;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  programming_mode, bus_in,
    output ack0, ack1, rdata,
    output bus_out, bus_oe,
    output set_mar, read_m, write_m,
    output busy, grant_id
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output programming_mode, bus_in,
    input  ack0, ack1, rdata,
    input  bus_out, bus_oe,
    input  set_mar, read_m, write_m,
    input  busy, grant_id
  );

endinterface

// File: rtl/mem_access_arbiter_select.sv
// ---------------------------------------------------------------------------
// mem_arb_select
// Purely combinational two-input arbiter.
//   rrLast_i : requester granted most recently (round-robin build only)
//   req_i    : {req1, req0}
//   winner_o : index of the winning requester
//   valid_o  : at least one request is present
// Build option MEM_ARB_FIXED_PRIO_EN: when defined, requester 1 always wins
// a tie and no round-robin history is needed; when undefined, a tie goes to
// the requester that was not granted last.
// ---------------------------------------------------------------------------
module mem_arb_select (
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic       rrLast_i,
`endif
  input  logic [1:0] req_i,
  output logic       winner_o,
  output logic       valid_o
);

  // Pick a winner among the active requests; ties resolved by build option.
  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    unique case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      2'b11:   winner_o = 1'b1;
`else
      2'b11:   winner_o = ~rrLast_i;
`endif
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
// Shares the single MemoryController port between requester 0 (CPU) and
// requester 1 (loader/DMA), turning each req/ack transaction into the
// set_mar -> read_m/write_m strobe sequence and owning the data-bus enable.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mem_access_arbiter_if.slave (requester ports, strobes, bus)
// Build option MEM_ARB_FIXED_PRIO_EN: requester 1 always wins contention and
// the round-robin history register is not built. Default: round-robin.
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_arbiter_if.slave   bus
);

  import mem_arb_pkg::*;

  arb_state_t        state_q, state_d;
  logic              weLat_q;
  logic [ADDR_W-1:0] addrLat_q;
  logic [DATA_W-1:0] wdataLat_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grantId_q;
  logic              winner;
  logic              winValid;
  logic              grantNow;
  logic [DATA_W-1:0] addrExt;

  logic              setMar;
  logic              readM;
  logic              writeM;
  logic              busOe;
  logic [DATA_W-1:0] busOut;
  logic              ack0;
  logic              ack1;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic              rrLast_q;
`endif

  mem_arb_select u_select (
`ifndef MEM_ARB_FIXED_PRIO_EN
    .rrLast_i (rrLast_q),
`endif
    .req_i    ({bus.req1, bus.req0}),
    .winner_o (winner),
    .valid_o  (winValid)
  );

  // A grant only happens from IDLE, and never while the front panel owns memory.
  assign grantNow = (state_q == ARB_IDLE) && winValid && !bus.programming_mode;

  // State register: one state per cycle through the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for a grant, the rest advance unconditionally.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (grantNow) state_d = ARB_ADDR;
      ARB_ADDR: state_d = ARB_DATA;
      ARB_DATA: state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Transaction capture: the winner's request is frozen at grant so later
  // changes on the requester side cannot disturb the access in flight.
  // Read data is sampled from the bus on the edge leaving DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      weLat_q    <= 1'b0;
      addrLat_q  <= '0;
      wdataLat_q <= '0;
      rdata_q    <= '0;
      grantId_q  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rrLast_q   <= 1'b1;
`endif
    end else begin
      if (grantNow) begin
        weLat_q    <= winner ? bus.we1    : bus.we0;
        addrLat_q  <= winner ? bus.addr1  : bus.addr0;
        wdataLat_q <= winner ? bus.wdata1 : bus.wdata0;
        grantId_q  <= winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rrLast_q   <= winner;
`endif
      end
      if ((state_q == ARB_DATA) && !weLat_q) begin
        rdata_q <= bus.bus_in;
      end
    end
  end

  // Zero-extend the latched address onto the wider data bus.
  always_comb begin
    addrExt                = '0;
    addrExt[ADDR_W-1:0]    = addrLat_q;
  end

  // Output decode: strobes and bus drive follow the state alone, so at most
  // one strobe is active and DONE always leaves the bus undriven.
  always_comb begin
    setMar = 1'b0;
    readM  = 1'b0;
    writeM = 1'b0;
    busOe  = 1'b0;
    busOut = '0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    unique case (state_q)
      ARB_ADDR: begin
        setMar = 1'b1;
        busOe  = 1'b1;
        busOut = addrExt;
      end
      ARB_DATA: begin
        if (weLat_q) begin
          writeM = 1'b1;
          busOe  = 1'b1;
          busOut = wdataLat_q;
        end else begin
          readM  = 1'b1;
        end
      end
      ARB_DONE: begin
        ack0 = !grantId_q;
        ack1 = grantId_q;
      end
      default: begin
        setMar = 1'b0;
      end
    endcase
  end

  assign bus.set_mar  = setMar;
  assign bus.read_m   = readM;
  assign bus.write_m  = writeM;
  assign bus.bus_oe   = busOe;
  assign bus.bus_out  = busOut;
  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.rdata    = rdata_q;
  assign bus.grant_id = grantId_q;
  assign bus.busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_access_arbiter
// Self-checking bench for mem_access_arbiter. Contains a small memory model
// standing in for the MemoryController, a table of single transactions, hand
// sequences for contention/programming/reset corners, and a randomized phase
// checked against a transaction-level reference model.
// Honors MEM_ARB_FIXED_PRIO_EN for the expected arbitration outcome.
// ---------------------------------------------------------------------------
module tb_mem_access_arbiter;

  typedef struct {
    logic        rid;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_access_arbiter_if bus();

  mem_access_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory controller model: latch MAR on set_mar, store on write_m, and
  // drive the bus with the stored word while read_m is high.
  logic [15:0] mem [0:255];
  logic [15:0] mar;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
      mar <= 16'h0;
    end else begin
      if (bus.set_mar) mar <= bus.bus_in;
      if (bus.write_m) mem[mar[7:0]] <= bus.bus_in;
    end
  end

  assign bus.bus_in = bus.read_m ? mem[mar[7:0]] : (bus.bus_oe ? bus.bus_out : 16'h0);

  // Random-phase model state
  vec_t        vecs[$];
  logic        pend [2];
  logic        rWe [2];
  logic [15:0] rAddr [2];
  logic [15:0] rWdata [2];
  int          waitCnt [2];
  logic [15:0] refMem [8];
  logic        modelLast;
  logic        inFlight;
  logic        expId;
  logic        prevExpBusy;
  int          grantCycle;
  logic [1:0]  reqsDriven;
  logic [1:0]  expAck;
  logic        expIds [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rid, input logic req, input logic we,
                               input logic [15:0] addr, input logic [15:0] wdata);
    if (rid) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, ".strobes"}, 32'({bus.set_mar, bus.read_m, bus.write_m}), 32'h0);
    checkOutput({name, ".bus_oe"}, 32'(bus.bus_oe), 32'h0);
    checkOutput({name, ".busy"}, 32'(bus.busy), 32'h0);
  endtask

  // One full uncontended transaction with per-cycle checks. The request
  // fields are scrambled after grant; the access must use the latched copy.
  task automatic runTxn(input vec_t v);
    applyStimulus(v.rid, 1'b1, v.we, v.addr, v.wdata);
    tick();
    checkOutput("addr.strobes", 32'({bus.set_mar, bus.read_m, bus.write_m}), 32'b100);
    checkOutput("addr.bus_oe", 32'(bus.bus_oe), 32'h1);
    checkOutput("addr.bus_out", 32'(bus.bus_out), 32'(v.addr));
    checkOutput("addr.grant_id", 32'(bus.grant_id), 32'(v.rid));
    checkOutput("addr.busy", 32'(bus.busy), 32'h1);
    applyStimulus(v.rid, 1'b1, v.we, ~v.addr, ~v.wdata);
    tick();
    if (v.we) begin
      checkOutput("data.strobes", 32'({bus.set_mar, bus.read_m, bus.write_m}), 32'b001);
      checkOutput("data.bus_oe", 32'(bus.bus_oe), 32'h1);
      checkOutput("data.bus_out", 32'(bus.bus_out), 32'(v.wdata));
    end else begin
      checkOutput("data.strobes", 32'({bus.set_mar, bus.read_m, bus.write_m}), 32'b010);
      checkOutput("data.bus_oe", 32'(bus.bus_oe), 32'h0);
    end
    tick();
    checkOutput("done.acks", 32'({bus.ack1, bus.ack0}), v.rid ? 32'b10 : 32'b01);
    checkOutput("done.strobes", 32'({bus.set_mar, bus.read_m, bus.write_m}), 32'h0);
    checkOutput("done.bus_oe", 32'(bus.bus_oe), 32'h0);
    if (!v.we) checkOutput("done.rdata", 32'(bus.rdata), 32'(v.expRdata));
    applyStimulus(v.rid, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    checkOutput("idle.acks", 32'({bus.ack1, bus.ack0}), 32'h0);
    checkOutput("idle.busy", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    bus.programming_mode = 1'b0;

    // Table: single write/read-back, then ten loader writes and CPU reads.
    vecs.push_back('{rid: 1'b0, we: 1'b1, addr: 16'h0005, wdata: 16'h00FA, expRdata: 16'h0});
    vecs.push_back('{rid: 1'b0, we: 1'b0, addr: 16'h0005, wdata: 16'h0, expRdata: 16'h00FA});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{rid: 1'b1, we: 1'b1, addr: 16'(i), wdata: 16'(255 - i), expRdata: 16'h0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{rid: 1'b0, we: 1'b0, addr: 16'(i), wdata: 16'h0, expRdata: 16'(255 - i)});

    // Reset state
    tick();
    tick();
    checkQuiet("reset");
    checkOutput("reset.acks", 32'({bus.ack1, bus.ack0}), 32'h0);
    checkOutput("reset.bus_out", 32'(bus.bus_out), 32'h0);
    checkOutput("reset.rdata", 32'(bus.rdata), 32'h0);
    checkOutput("reset.grant_id", 32'(bus.grant_id), 32'h0);
    reset = 1'b0;
    tick();

    foreach (vecs[k]) runTxn(vecs[k]);

    // Programming mode raised during ADDR: read finishes, later req1 waits.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
    tick();
    checkOutput("pm.addr_set_mar", 32'(bus.set_mar), 32'h1);
    bus.programming_mode = 1'b1;
    tick();
    checkOutput("pm.data_read_m", 32'(bus.read_m), 32'h1);
    tick();
    checkOutput("pm.done_acks", 32'({bus.ack1, bus.ack0}), 32'b01);
    checkOutput("pm.done_rdata", 32'(bus.rdata), 32'h00FC);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0030, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkQuiet("pm.blocked");
    end
    bus.programming_mode = 1'b0;
    tick();
    checkOutput("pm.release_set_mar", 32'(bus.set_mar), 32'h1);
    checkOutput("pm.release_grant", 32'(bus.grant_id), 32'h1);
    checkOutput("pm.release_bus_out", 32'(bus.bus_out), 32'h0030);
    tick();
    checkOutput("pm.release_write_m", 32'(bus.write_m), 32'h1);
    tick();
    checkOutput("pm.release_ack", 32'({bus.ack1, bus.ack0}), 32'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Reset during DATA of a write: everything returns to reset, no ack.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0050, 16'h1234);
    tick();
    tick();
    checkOutput("rst.data_write_m", 32'(bus.write_m), 32'h1);
    reset = 1'b1;
    tick();
    checkQuiet("rst.abort");
    checkOutput("rst.acks", 32'({bus.ack1, bus.ack0}), 32'h0);
    checkOutput("rst.grant_id", 32'(bus.grant_id), 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    checkOutput("rst.after_acks", 32'({bus.ack1, bus.ack0}), 32'h0);

    // Contention from a fresh reset: both held high back-to-back.
`ifdef MEM_ARB_FIXED_PRIO_EN
    expIds = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    expIds = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("cont.set_mar", 32'(bus.set_mar), 32'h1);
      checkOutput("cont.grant_id", 32'(bus.grant_id), 32'(expIds[k]));
      tick();
      checkOutput("cont.data_strobes", 32'({bus.set_mar, bus.read_m, bus.write_m}), 32'b010);
      tick();
      checkOutput("cont.acks", 32'({bus.ack1, bus.ack0}), expIds[k] ? 32'b10 : 32'b01);
      if (k == 3) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      tick();
      checkQuiet("cont.idle");
    end

    // Long idle with no requests.
    for (int i = 0; i < 20; i++) begin
      tick();
      checkQuiet("idle20");
    end

    // Randomized phase against the transaction-level model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) refMem[i] = 16'h0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; rWe[r] = 1'b0; rAddr[r] = 16'h0; rWdata[r] = 16'h0; waitCnt[r] = 0;
    end
    modelLast   = 1'b1;
    inFlight    = 1'b0;
    expId       = 1'b0;
    prevExpBusy = 1'b0;
    grantCycle  = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reqsDriven = {bus.req1, bus.req0};
      tick();
      if (!prevExpBusy && (reqsDriven != 2'b00)) begin
        if (reqsDriven == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          expId = 1'b1;
`else
          expId = ~modelLast;
`endif
        end else begin
          expId = reqsDriven[1];
        end
        modelLast  = expId;
        inFlight   = 1'b1;
        grantCycle = cyc;
        checkOutput("rand.grant_id", 32'(bus.grant_id), 32'(expId));
      end
      checkOutput("rand.busy", 32'(bus.busy), 32'(inFlight));
      checkOutput("rand.strobe_excl", 32'($countones({bus.set_mar, bus.read_m, bus.write_m}) <= 1), 32'h1);
      checkOutput("rand.oe_phase", 32'(!bus.bus_oe || bus.set_mar || bus.write_m), 32'h1);
      expAck = (inFlight && (cyc == grantCycle + 2)) ? (expId ? 2'b10 : 2'b01) : 2'b00;
      checkOutput("rand.acks", 32'({bus.ack1, bus.ack0}), 32'(expAck));
      prevExpBusy = inFlight;
      if (expAck != 2'b00) begin
        if (!rWe[expId])
          checkOutput("rand.rdata", 32'(bus.rdata), 32'(refMem[rAddr[expId][2:0]]));
        else
          refMem[rAddr[expId][2:0]] = rWdata[expId];
        inFlight       = 1'b0;
        pend[expId]    = 1'b0;
        waitCnt[expId] = 0;
      end
      for (int r = 0; r < 2; r++) begin
        if (pend[r]) begin
          waitCnt[r]++;
          if (waitCnt[r] > 16) begin
            checks++;
            errors++;
            $display("[TB] FAIL rand.timeout: requester %0d waited %0d cycles, limit 16", r, waitCnt[r]);
            pend[r]    = 1'b0;
            waitCnt[r] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          pend[r]    = 1'b1;
          rWe[r]     = 1'($urandom_range(0, 1));
          rAddr[r]   = 16'h0040 + 16'($urandom_range(0, 7));
          rWdata[r]  = 16'($urandom);
          waitCnt[r] = 0;
        end
        applyStimulus(1'(r), pend[r], rWe[r], rAddr[r], rWdata[r]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
